// File: rtl/slope_calc.sv
// rtl/slope_calc.sv - segment slope operand stage in front of the signed divider
//
// Accepts a segment (x0,y0)->(x1,y1), forms dx/dy, feeds non-negative
// magnitudes to the downstream divider and returns a signed fixed-point
// slope dy/dx with FRAC fraction bits.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   segment handshake (in_ready high only in IDLE)
//   x0, y0, x1, y1       two's-complement endpoint coordinates
//   div_a, div_b         registered dividend / divisor to the divider
//   div_res              combinational quotient from the divider
//   out_valid, out_ready result handshake
//   slope                signed slope, FRAC fraction bits
//   vertical             dx == 0
//   overflow             slope not representable, slope saturated
module slope_calc #(
    parameter int N    = 32,
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x0,
    input  logic [N-1:0] y0,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    output logic [N-1:0] div_a,
    output logic [N-1:0] div_b,
    input  logic [N-1:0] div_res,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] slope,
    output logic         vertical,
    output logic         overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIFF  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // |dy| at or above this bound would spill into the sign bit once
    // shifted left by FRAC.
    localparam logic [N-1:0] OVF_LIM = {{(N-1){1'b0}}, 1'b1} << (N - 1 - FRAC);
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    // Negative saturation is symmetric with the positive one (-max), not
    // the most negative code.
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-2){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [N-1:0] x0_r, y0_r, x1_r, y1_r;
    logic         neg_r;

    logic [N-1:0] dx, dy, adx, ady;
    logic         neg, dx_zero, too_big;

    // Difference and magnitude logic, only meaningful in DIFF.
    always_comb begin
        dx      = x1_r - x0_r;
        dy      = y1_r - y0_r;
        neg     = dx[N-1] ^ dy[N-1];
        adx     = dx[N-1] ? (~dx + 1'b1) : dx;
        ady     = dy[N-1] ? (~dy + 1'b1) : dy;
        dx_zero = (dx == '0);
        // Magnitude bit N-1 still set after negation means the most negative
        // code, which has no positive counterpart.
        too_big = adx[N-1] | ady[N-1] | (ady >= OVF_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = DIFF;
                end
            end
            DIFF: begin
                if (dx_zero || too_big) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_r     <= '0;
            y0_r     <= '0;
            x1_r     <= '0;
            y1_r     <= '0;
            neg_r    <= 1'b0;
            div_a    <= '0;
            div_b    <= '0;
            slope    <= '0;
            vertical <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x0_r <= x0;
                        y0_r <= y0;
                        x1_r <= x1;
                        y1_r <= y1;
                    end
                end
                DIFF: begin
                    neg_r <= neg;
                    if (dx_zero) begin
                        // Divider operands deliberately left untouched.
                        vertical <= 1'b1;
                        overflow <= 1'b0;
                        slope    <= '0;
                    end else if (too_big) begin
                        vertical <= 1'b0;
                        overflow <= 1'b1;
                        slope    <= neg ? SAT_NEG : SAT_POS;
                    end else begin
                        div_a <= ady << FRAC;
                        div_b <= adx;
                    end
                end
                ISSUE: begin
                    // Quotient of magnitudes truncates, so re-applying the
                    // sign yields round-toward-zero.
                    slope    <= neg_r ? (~div_res + 1'b1) : div_res;
                    vertical <= 1'b0;
                    overflow <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slope_calc.sv
// tb/tb_slope_calc.sv - directed vector bench for slope_calc
module tb_slope_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x0, y0, x1, y1;
    logic [31:0] div_a, div_b, div_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] slope;
    logic        vertical;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural divider: operands are non-negative, so plain unsigned
    // truncating division matches the real block.
    assign div_res = (div_b == 32'd0) ? 32'd0 : (div_a / div_b);

    slope_calc #(.N(32), .FRAC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .div_a(div_a), .div_b(div_b), .div_res(div_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .slope(slope), .vertical(vertical), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] x0, y0, x1, y1;
        logic [31:0] e_slope;
        logic        e_vert;
        logic        e_ovf;
        int          e_lat;
        logic [31:0] e_div_a;
        logic [31:0] e_div_b;
    } seg_t;

    seg_t vec[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one segment, measure latency, check results, complete transfer.
    task automatic run_seg(input seg_t s, input string tag);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        x0 = s.x0; y0 = s.y0; x1 = s.x1; y1 = s.y1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, s.e_lat);
        chk({tag, " slope"}, slope, s.e_slope);
        chk({tag, " vertical"}, {31'd0, vertical}, {31'd0, s.e_vert});
        chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, s.e_ovf});
        chk({tag, " div_a"}, div_a, s.e_div_a);
        chk({tag, " div_b"}, div_b, s.e_div_b);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid after xfer"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " in_ready after xfer"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int          seen;
        seg_t        s;

        //         x0           y0            x1            y1            slope         v     o     lat div_a    div_b
        vec[0] = '{32'd0,       32'd0,        32'd4,        32'd2,        32'h00000080, 1'b0, 1'b0, 3, 32'd512,  32'd4};
        vec[1] = '{32'd0,       32'd0,        32'd4,        -32'sd2,      32'hFFFFFF80, 1'b0, 1'b0, 3, 32'd512,  32'd4};
        vec[2] = '{32'd0,       32'd0,        32'd3,        -32'sd1,      32'hFFFFFFAB, 1'b0, 1'b0, 3, 32'd256,  32'd3};
        vec[3] = '{32'd5,       32'd1,        32'd5,        32'd9,        32'h00000000, 1'b1, 1'b0, 2, 32'd256,  32'd3};
        vec[4] = '{32'd0,       32'd0,        32'd1,        32'h00800000, 32'h7FFFFFFF, 1'b0, 1'b1, 2, 32'd256,  32'd3};
        vec[5] = '{32'd0,       32'd0,        -32'sd1,      32'h00800000, 32'h80000001, 1'b0, 1'b1, 2, 32'd256,  32'd3};
        vec[6] = '{32'd0,       32'd0,        32'h80000000, 32'd1,        32'h80000001, 1'b0, 1'b1, 2, 32'd256,  32'd3};
        vec[7] = '{32'd0,       32'd0,        32'd7,        32'd0,        32'h00000000, 1'b0, 1'b0, 3, 32'd0,    32'd7};
        vec[8] = '{32'd10,      32'd20,       32'd2,        32'd4,        32'h00000200, 1'b0, 1'b0, 3, 32'd4096, 32'd8};
        vec[9] = '{32'd0,       32'd0,        32'd0,        32'd0,        32'h00000000, 1'b1, 1'b0, 2, 32'd4096, 32'd8};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #1;
        chk("reset slope", slope, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset div_a", div_a, 32'd0);
        chk("reset div_b", div_b, 32'd0);
        chk("reset flags", {30'd0, vertical, overflow}, 32'd0);
        // Handshake during reset must be ignored.
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_seg(vec[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 5 cycles with in_valid pulses.
        x0 = 32'd0; y0 = 32'd0; x1 = 32'd4; y1 = 32'd2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        held = slope;
        chk("bp slope", held, 32'h00000080);
        x0 = 32'd0; y0 = 32'd0; x1 = 32'd1; y1 = 32'd1;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            @(negedge clk);
            chk($sformatf("bp hold slope c%0d", c), slope, held);
            chk($sformatf("bp hold flags c%0d", c), {29'd0, out_valid, vertical, overflow}, 32'd4);
            chk($sformatf("bp in_ready c%0d", c), {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp single transfer", {30'd0, out_valid, in_ready}, 32'd1);
        s = '{32'd0, 32'd0, 32'd2, 32'd2, 32'h00000100, 1'b0, 1'b0, 3, 32'd512, 32'd2};
        run_seg(s, "bp next");

        // Reset in ISSUE aborts the segment.
        x0 = 32'd0; y0 = 32'd0; x1 = 32'd4; y1 = 32'd2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-reset slope", slope, 32'd0);
        chk("mid-reset div_a", div_a, 32'd0);
        chk("mid-reset div_b", div_b, 32'd0);
        chk("mid-reset flags", {29'd0, out_valid, vertical, overflow}, 32'd0);
        chk("mid-reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("aborted no out_valid", seen, 32'd0);
        run_seg(s, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slope_calc.md
# slope_calc

Sequential operand stage that sits directly upstream of the signed `div` block in the shapes datapath. It accepts a line segment (x0,y0)→(x1,y1) over a valid/ready handshake and forms dx and dy. It drives non-negative magnitudes into the divider and captures the quotient. It returns a signed fixed-point slope dy/dx with FRAC fraction bits to the rasterizer, and flags vertical and overflow cases.

## Interface
- `N`, 32, datapath width; must be 32 because the divider keys on bit 31.
- `FRAC`, 8, fraction bits of the slope output, in the range 1..16.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  the segment on x0/y0/x1/y1 is valid.
- `in_ready`  out  1  high only in IDLE.
- `x0, y0, x1, y1`  in  N each  two's-complement endpoint coordinates.
- `div_a`  out  N  dividend to `div`; registered.
- `div_b`  out  N  divisor to `div`; registered.
- `div_res`  in  N  combinational quotient returned by `div`.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  the consumer accepts the result.
- `slope`  out  N  signed slope, two's complement, FRAC fraction bits.
- `vertical`  out  1  dx == 0.
- `overflow`  out  1  the slope is not representable; `slope` holds the saturated value.

## Operation
- FSM states: IDLE, DIFF, ISSUE, DONE.
- IDLE
  - `in_ready` = 1.
  - When `in_valid` & `in_ready`, register x0/y0/x1/y1 and go to DIFF.
- DIFF
  - dx = x1−x0 and dy = y1−y0, both N-bit wrapping subtraction.
  - neg = dx[N−1] ^ dy[N−1].
  - |dx| and |dy| are formed by two's-complement negation (~v+1). Ones' complement is not allowed.
  - If dx == 0: vertical=1, overflow=0, slope=0, go to DONE. `div_a`/`div_b` are not touched.
  - Else if |dx|[N−1]=1, or |dy|[N−1]=1, or |dy| ≥ 2^(N−1−FRAC): overflow=1, vertical=0, go to DONE.
    - slope = 0x7FFFFFFF when neg=0.
    - slope = 0x80000001 when neg=1.
  - Else: load div_a = |dy| << FRAC and div_b = |dx|, then go to ISSUE.
- ISSUE
  - `div` sees only non-negative operands, so its internal sign logic is inert and div_res = div_a / div_b, truncated.
  - slope = neg ? (~div_res + 1) : div_res. This truncates toward zero.
  - vertical=0, overflow=0, go to DONE.
- DONE
  - `out_valid` = 1.
  - slope, vertical and overflow hold stable until `out_ready`.
  - When `out_ready` is high, go to IDLE.
- No new input is accepted outside IDLE; there is no result buffering.
- dy = 0 with dx ≠ 0 produces slope 0, vertical=0.

## Timing
- Reset (rst_n low, asynchronous)
  - state = IDLE.
  - slope, div_a, div_b = 0.
  - out_valid, vertical, overflow = 0.
  - `in_ready` = 1, but handshakes are ignored while rst_n is low.
- Latency, counted from the accept edge:
  - Normal path: DIFF in cycle 1, ISSUE in cycle 2, `out_valid` high in cycle 3.
  - Vertical and overflow paths: `out_valid` high in cycle 2.
- `div` must settle within one clock: the operands are registered on the DIFF→ISSUE edge and `div_res` is sampled on the ISSUE→DONE edge.
- Output handshake:
  - A transfer occurs on any edge with out_valid & out_ready.
  - `in_ready` rises in the following cycle, so at best one segment is accepted every 4 cycles (3 on the vertical path).
  - `out_valid` never drops without `out_ready`.
- Reset mid-operation: an asserted rst_n aborts immediately to the reset values. The partial result is discarded and nothing is emitted.

## Test plan
- Positive slope, FRAC=8: (0,0)→(4,2) → div_a=512, div_b=4, slope=0x00000080, vertical=0, overflow=0, out_valid 3 cycles after accept.
- Negative slope and truncation: (0,0)→(4,−2) → slope=0xFFFFFF80. (0,0)→(3,−1) → div_a=256, div_b=3, slope=−85 (0xFFFFFFAB).
- Vertical: (5,1)→(5,9) → vertical=1, slope=0, div_a/div_b keep their prior values, out_valid 2 cycles after accept.
- Overflow:
  - (0,0)→(1,0x00800000) → overflow=1, slope=0x7FFFFFFF.
  - (0,0)→(−1,0x00800000) → slope=0x80000001.
  - (0,0)→(0x80000000,1) → overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → slope/flags stable, in_ready=0, in_valid pulses ignored. Raise out_ready → one transfer, then IDLE, then the next segment is accepted.
- Reset mid-op: pull rst_n low during ISSUE → all outputs 0 asynchronously. After release, in_ready=1, out_valid never pulses for the aborted segment, and the next segment (0,0)→(2,2) yields 0x00000100.
